// File: rtl/iiitb_rtc_alarm.sv
// Real-time clock: 24-hour BCD time base, 12/24-hour display, validated time load, optional alarm.
// Define RTC_ALARM_EN to build the alarm compare; without it alarm_irq is tied low.
module iiitb_rtc_alarm #(
   parameter int CLK_FREQ_HZ = 1000,
   parameter int DIV_W       = $clog2(CLK_FREQ_HZ)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode12,
   input  logic        set_valid,
   output logic        set_ready,
   input  logic [23:0] set_time,
   output logic        set_err,
   input  logic [15:0] alarm_time,
   input  logic        alarm_en,
   input  logic        alarm_ack,
   output logic        alarm_irq,
   output logic        tick_1hz,
   output logic        day_tick,
   output logic [3:0]  hrm,
   output logic [3:0]  hrl,
   output logic [3:0]  minm,
   output logic [3:0]  minl,
   output logic [3:0]  secm,
   output logic [3:0]  secl,
   output logic        pm
);

   typedef struct packed {
      logic [3:0] hrm;
      logic [3:0] hrl;
      logic [3:0] minm;
      logic [3:0] minl;
      logic [3:0] secm;
      logic [3:0] secl;
   } bcd_time_t;

   bcd_time_t        r_time;
   bcd_time_t        w_time_inc;
   bcd_time_t        w_set;
   logic [DIV_W-1:0] r_presc;
   logic             r_busy;
   logic             r_set_err;
   logic             w_accept;
   logic             w_load_ok;
   logic             w_tick;
   logic             w_advance;
   logic             w_day_wrap;
   logic [4:0]       w_hr_bin;
   logic [4:0]       w_hr12;

   assign w_set     = bcd_time_t'(set_time);
   assign w_tick    = (r_presc == DIV_W'(CLK_FREQ_HZ - 1)) && !rst;
   assign set_ready = !r_busy;
   assign w_accept  = set_valid && !r_busy;
   assign w_advance = w_tick && !w_accept;

   assign w_load_ok = (w_set.secl <= 4'd9) && (w_set.secm <= 4'd5) &&
                      (w_set.minl <= 4'd9) && (w_set.minm <= 4'd5) &&
                      (w_set.hrl  <= 4'd9) &&
                      ((w_set.hrm < 4'd2) || ((w_set.hrm == 4'd2) && (w_set.hrl <= 4'd3)));

   // Ripple-carry BCD increment of the whole time; w_day_wrap flags 23:59:59 -> 00:00:00.
   always_comb begin
      w_time_inc = r_time;
      w_day_wrap = 1'b0;
      if (r_time.secl != 4'd9) begin
         w_time_inc.secl = r_time.secl + 4'd1;
      end else begin
         w_time_inc.secl = 4'd0;
         if (r_time.secm != 4'd5) begin
            w_time_inc.secm = r_time.secm + 4'd1;
         end else begin
            w_time_inc.secm = 4'd0;
            if (r_time.minl != 4'd9) begin
               w_time_inc.minl = r_time.minl + 4'd1;
            end else begin
               w_time_inc.minl = 4'd0;
               if (r_time.minm != 4'd5) begin
                  w_time_inc.minm = r_time.minm + 4'd1;
               end else begin
                  w_time_inc.minm = 4'd0;
                  if ((r_time.hrm == 4'd2) && (r_time.hrl == 4'd3)) begin
                     w_time_inc.hrm = 4'd0;
                     w_time_inc.hrl = 4'd0;
                     w_day_wrap     = 1'b1;
                  end else if (r_time.hrl == 4'd9) begin
                     w_time_inc.hrm = r_time.hrm + 4'd1;
                     w_time_inc.hrl = 4'd0;
                  end else begin
                     w_time_inc.hrl = r_time.hrl + 4'd1;
                  end
               end
            end
         end
      end
   end

   // NOTE: reset is the first branch so it overrides load, tick and the handshake in one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_time    <= '0;
         r_presc   <= '0;
         r_busy    <= 1'b0;
         r_set_err <= 1'b0;
      end else begin
         r_busy    <= w_accept;
         r_set_err <= w_accept && !w_load_ok;
         if (w_accept && w_load_ok) begin
            r_time  <= w_set;
            r_presc <= '0;
         end else begin
            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
            if (w_advance) r_time <= w_time_inc;
         end
      end
   end

   assign tick_1hz = w_tick;
   assign day_tick = w_advance && w_day_wrap;
   assign set_err  = r_set_err;

   // Display path is purely combinational so a mode12 change shows in the same cycle.
   assign w_hr_bin = 5'(r_time.hrm) * 5'd10 + 5'(r_time.hrl);
   assign pm       = (w_hr_bin >= 5'd12);

   always_comb begin
      w_hr12 = w_hr_bin;
      if (w_hr_bin == 5'd0)       w_hr12 = 5'd12;
      else if (w_hr_bin > 5'd12)  w_hr12 = w_hr_bin - 5'd12;
      hrm = r_time.hrm;
      hrl = r_time.hrl;
      if (mode12) begin
         hrm = (w_hr12 >= 5'd10) ? 4'd1 : 4'd0;
         hrl = 4'((w_hr12 >= 5'd10) ? (w_hr12 - 5'd10) : w_hr12);
      end
   end

   assign minm = r_time.minm;
   assign minl = r_time.minl;
   assign secm = r_time.secm;
   assign secl = r_time.secl;

`ifdef RTC_ALARM_EN
   logic r_alarm_irq;
   logic w_alarm_hit;

   // Match on the value the tick is about to produce, so a load can never raise the alarm.
   assign w_alarm_hit = alarm_en && w_advance &&
                        (w_time_inc.secm == 4'd0) && (w_time_inc.secl == 4'd0) &&
                        ({w_time_inc.hrm, w_time_inc.hrl, w_time_inc.minm, w_time_inc.minl} == alarm_time);

   always_ff @(posedge clk) begin
      if (rst)              r_alarm_irq <= 1'b0;
      else if (w_alarm_hit) r_alarm_irq <= 1'b1;
      else if (alarm_ack)   r_alarm_irq <= 1'b0;
   end

   assign alarm_irq = r_alarm_irq;
`else
   logic w_unused_alarm;
   assign w_unused_alarm = ^{alarm_time, alarm_en, alarm_ack};
   assign alarm_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_rtc_alarm.sv
// Scoreboard bench for iiitb_rtc_alarm at CLK_FREQ_HZ=4; alarm expectations follow RTC_ALARM_EN.
module tb_iiitb_rtc_alarm;
`ifdef RTC_ALARM_EN
   localparam logic ALARM_ON = 1'b1;
`else
   localparam logic ALARM_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode12 = 1'b0;
   logic        set_valid = 1'b0;
   logic        set_ready;
   logic [23:0] set_time = '0;
   logic        set_err;
   logic [15:0] alarm_time = '0;
   logic        alarm_en = 1'b0;
   logic        alarm_ack = 1'b0;
   logic        alarm_irq, tick_1hz, day_tick, pm;
   logic [3:0]  hrm, hrl, minm, minl, secm, secl;
   logic [23:0] disp;

   assign disp = {hrm, hrl, minm, minl, secm, secl};

   iiitb_rtc_alarm #(.CLK_FREQ_HZ(4)) dut (
      .clk(clk), .rst(rst), .mode12(mode12),
      .set_valid(set_valid), .set_ready(set_ready), .set_time(set_time), .set_err(set_err),
      .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack), .alarm_irq(alarm_irq),
      .tick_1hz(tick_1hz), .day_tick(day_tick),
      .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl), .secm(secm), .secl(secl), .pm(pm)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [23:0] exp;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input string n, input logic [23:0] v);
      exp_t x;
      x.name = n;
      x.exp  = v;
      sb.push_back(x);
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick_clk();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick_clk();
      rst = 1'b0;
   endtask

   // Drives one accepted load; returns in the cycle after the accept.
   task automatic load(input logic [23:0] v);
      set_valid = 1'b1;
      set_time  = v;
      tick_clk();
      set_valid = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; set_valid = 1'b1; set_time = 24'h123456; mode12 = 1'b0;
      run(2);
      rst = 1'b0; set_valid = 1'b0;
      push_exp("rst_time", 24'h000000); push_exp("rst_pm", 24'd0);
      push_exp("rst_tick", 24'd0); push_exp("rst_day", 24'd0);
      push_exp("rst_ready", 24'd1); push_exp("rst_err", 24'd0); push_exp("rst_irq", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(pm) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, pm, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(day_tick) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, day_tick, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(set_ready) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_ready, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(set_err) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_err, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      mode12 = 1'b1;
      push_exp("rst_time_12h", 24'h120000);
      #1;
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      mode12 = 1'b0;
      tick_clk();
   endtask

   task automatic test_count();
      exp_t e;
      do_reset();
      for (int c = 1; c <= 12; c++) push_exp($sformatf("tick_c%0d", c), 24'((c % 4) == 0));
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
         tick_clk();
      end
      push_exp("time_after_12_cycles", 24'h000003);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      tick_clk();
   endtask

   task automatic test_rollover();
      exp_t e;
      mode12 = 1'b0;
      load(24'h235958);
      for (int c = 1; c <= 8; c++) begin
         push_exp($sformatf("roll_tick_c%0d", c), 24'((c == 4) || (c == 8)));
         push_exp($sformatf("roll_day_c%0d", c), 24'(c == 8));
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
         e = sb.pop_front(); n_tests++; if (24'(day_tick) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, day_tick, e.exp); end
         if (c == 5) begin
            push_exp("roll_235959", 24'h235959);
            e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
         end
         tick_clk();
      end
      push_exp("roll_000000", 24'h000000); push_exp("roll_pm", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(pm) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, pm, e.exp); end
      mode12 = 1'b1;
      push_exp("roll_120000_12h", 24'h120000); push_exp("roll_pm_12h", 24'd0);
      #1;
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(pm) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, pm, e.exp); end
      tick_clk();
   endtask

   task automatic test_mode12();
      exp_t e;
      logic [23:0] ld [8] = '{24'h000000, 24'h015959, 24'h115959, 24'h120000,
                              24'h130000, 24'h193000, 24'h200000, 24'h230000};
      logic [23:0] sh [8] = '{24'h120000, 24'h015959, 24'h115959, 24'h120000,
                              24'h010000, 24'h073000, 24'h080000, 24'h110000};
      logic        ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      mode12 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         load(ld[i]);
         push_exp($sformatf("m12_disp_%h", ld[i]), sh[i]);
         push_exp($sformatf("m12_pm_%h", ld[i]), 24'(ep[i]));
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
         e = sb.pop_front(); n_tests++; if (24'(pm) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, pm, e.exp); end
         tick_clk();
      end
      mode12 = 1'b0;
      push_exp("m24_disp_230000", 24'h230000);
      #1;
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
   endtask

   task automatic test_bad_load();
      exp_t e;
      logic [23:0] bad [7] = '{24'h136000, 24'h240000, 24'h001060, 24'h00000A,
                               24'h300000, 24'h0A0000, 24'h00A000};
      mode12 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         load(24'h101010);
         push_exp($sformatf("ready_low_after_accept_%0d", i), 24'd0);
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (24'(set_ready) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_ready, e.exp); end
         tick_clk();
         load(bad[i]);
         push_exp($sformatf("err_pulse_%h", bad[i]), 24'd1);
         push_exp($sformatf("err_ready_low_%h", bad[i]), 24'd0);
         push_exp($sformatf("err_time_kept_%h", bad[i]), 24'h101010);
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (24'(set_err) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_err, e.exp); end
         e = sb.pop_front(); n_tests++; if (24'(set_ready) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_ready, e.exp); end
         e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
         tick_clk();
         push_exp($sformatf("err_one_cycle_%h", bad[i]), 24'd0);
         push_exp($sformatf("ready_back_%h", bad[i]), 24'd1);
         @(negedge clk);
         e = sb.pop_front(); n_tests++; if (24'(set_err) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_err, e.exp); end
         e = sb.pop_front(); n_tests++; if (24'(set_ready) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_ready, e.exp); end
      end
      tick_clk();
      load(24'h235959);
      push_exp("boundary_235959_no_err", 24'd0); push_exp("boundary_235959_time", 24'h235959);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(set_err) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_err, e.exp); end
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      tick_clk();
   endtask

   task automatic test_load_on_tick();
      exp_t e;
      mode12 = 1'b0;
      load(24'h101010);
      run(3);
      set_valid = 1'b1;
      set_time  = 24'h081500;
      push_exp("tick_during_load", 24'd1);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
      tick_clk();
      set_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         push_exp($sformatf("presc_restart_c%0d", c), 24'(c == 4));
         @(negedge clk);
         if (c == 1) begin
            push_exp("load_wins_over_tick", 24'h081500);
            e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
            e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
         end else begin
            e = sb.pop_front(); n_tests++; if (24'(tick_1hz) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, tick_1hz, e.exp); end
         end
         tick_clk();
      end
      push_exp("first_tick_after_load", 24'h081501);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      tick_clk();
   endtask

   task automatic test_alarm();
      exp_t e;
      mode12 = 1'b0;
      alarm_time = 16'h0701;
      alarm_en = 1'b1;
      load(24'h070100);
      push_exp("load_never_sets_irq", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      tick_clk();
      load(24'h070059);
      run(3);
      push_exp("irq_before_tick", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      tick_clk();
      push_exp("irq_set", 24'(ALARM_ON)); push_exp("alarm_time_070100", 24'h070100);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      alarm_en = 1'b0;
      tick_clk();
      push_exp("irq_held_after_disarm", 24'(ALARM_ON));
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      alarm_ack = 1'b1;
      tick_clk();
      alarm_ack = 1'b0;
      push_exp("irq_cleared_by_ack", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      alarm_en = 1'b1;
      load(24'h070059);
      alarm_ack = 1'b1;
      run(4);
      alarm_ack = 1'b0;
      push_exp("irq_set_beats_ack", 24'(ALARM_ON));
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      alarm_en = 1'b0;
      alarm_ack = 1'b1;
      tick_clk();
      alarm_ack = 1'b0;
      load(24'h070059);
      run(4);
      push_exp("no_irq_when_disarmed", 24'd0); push_exp("disarmed_time", 24'h070100);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      tick_clk();
   endtask

   task automatic test_reset_midcount();
      exp_t e;
      mode12 = 1'b0;
      alarm_time = 16'h0701;
      alarm_en = 1'b1;
      load(24'h070059);
      run(4);
      load(24'h153012);
      tick_clk();
      push_exp("midcount_time", 24'h153012); push_exp("irq_kept_by_load", 24'(ALARM_ON));
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      rst = 1'b1; set_valid = 1'b1; set_time = 24'h112233;
      tick_clk();
      rst = 1'b0; set_valid = 1'b0;
      push_exp("mid_rst_time", 24'h000000); push_exp("mid_rst_irq", 24'd0);
      push_exp("mid_rst_ready", 24'd1); push_exp("mid_rst_err", 24'd0);
      @(negedge clk);
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(alarm_irq) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, alarm_irq, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(set_ready) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_ready, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(set_err) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, set_err, e.exp); end
      mode12 = 1'b1;
      push_exp("mid_rst_12h", 24'h120000); push_exp("mid_rst_pm", 24'd0);
      #1;
      e = sb.pop_front(); n_tests++; if (disp !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, disp, e.exp); end
      e = sb.pop_front(); n_tests++; if (24'(pm) !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, pm, e.exp); end
      tick_clk();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_count();
      test_rollover();
      test_mode12();
      test_bad_load();
      test_load_on_tick();
      test_alarm();
      test_reset_midcount();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
